// File: rtl/spu_pkg.sv
// Shared definitions for the SPU execution core: opcodes, Nyaya lane encoding,
// FSM states and the four-valued lane operators.
package spu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NY_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_NY_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_NY_NOT = 3'd2;
    localparam logic [OP_W-1:0] OP_ADD    = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL    = 3'd4;

    localparam logic [1:0] NY_F = 2'b00;
    localparam logic [1:0] NY_T = 2'b01;
    localparam logic [1:0] NY_B = 2'b10;
    localparam logic [1:0] NY_N = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // F absorbs, T is the identity; the two middle values meet at F.
    function automatic logic [1:0] ny_and(input logic [1:0] x, input logic [1:0] y);
        if (x == NY_F || y == NY_F) return NY_F;
        if (x == NY_T) return y;
        if (y == NY_T) return x;
        if (x == y) return x;
        return NY_F;
    endfunction

    // T absorbs, F is the identity; the two middle values join at T.
    function automatic logic [1:0] ny_or(input logic [1:0] x, input logic [1:0] y);
        if (x == NY_T || y == NY_T) return NY_T;
        if (x == NY_F) return y;
        if (y == NY_F) return x;
        if (x == y) return x;
        return NY_T;
    endfunction

    function automatic logic [1:0] ny_not(input logic [1:0] x);
        if (x == NY_T) return NY_F;
        if (x == NY_F) return NY_T;
        return x;
    endfunction

endpackage

// File: rtl/spu_cmd_fifo.sv
// Command queue for the SPU core: show-ahead FIFO with registered occupancy.
// Full blocks pushes regardless of a same-cycle pop.
module spu_cmd_fifo
    import spu_pkg::*;
#(
    parameter int ENTRY_W = 8,
    parameter int DEPTH   = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_rdata,
    output logic [CW-1:0]      o_count,
    output logic               o_empty,
    output logic               o_full
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/spu_exec_core.sv
// SPU execution core: queued tagged commands, Nyaya lane logic / add in one
// cycle, shift-add multiply over WIDTH cycles, tagged responses with backpressure.
module spu_exec_core
    import spu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_loop,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic [15:0]            loop_count
);

    localparam int LANES   = WIDTH / 2;
    localparam int ENTRY_W = OP_W + 2 * WIDTH + TAG_W;
    localparam int CNT_W   = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;

    logic [ENTRY_W-1:0] w_head;
    logic [OP_W-1:0]    w_head_op;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic [TAG_W-1:0]   w_head_tag;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_dispatch;
    logic               w_load_single;
    logic               w_load_mul;
    logic               w_step;

    logic [WIDTH-1:0]   w_and;
    logic [WIDTH-1:0]   w_or;
    logic [WIDTH-1:0]   w_not;
    logic [LANES-1:0]   w_and_b;
    logic [LANES-1:0]   w_or_b;
    logic [LANES-1:0]   w_not_b;

    logic [2*WIDTH-1:0] w_single_data;
    logic               w_single_loop;
    logic               w_single_err;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic               w_mul_last;

    logic [2*WIDTH-1:0] r_rsp_data;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_loop;
    logic               r_rsp_err;
    logic [15:0]        r_loop_cnt;

    spu_cmd_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_op, cmd_a, cmd_b, cmd_tag}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (fifo_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign cmd_ready  = ~w_full;
    assign w_head_op  = w_head[ENTRY_W-1 -: OP_W];
    assign w_head_a   = w_head[TAG_W+WIDTH +: WIDTH];
    assign w_head_b   = w_head[TAG_W +: WIDTH];
    assign w_head_tag = w_head[TAG_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_and[2*gi +: 2] = ny_and(w_head_a[2*gi +: 2], w_head_b[2*gi +: 2]);
            assign w_or[2*gi +: 2]  = ny_or(w_head_a[2*gi +: 2], w_head_b[2*gi +: 2]);
            assign w_not[2*gi +: 2] = ny_not(w_head_a[2*gi +: 2]);
            assign w_and_b[gi]      = (w_and[2*gi +: 2] == NY_B);
            assign w_or_b[gi]       = (w_or[2*gi +: 2] == NY_B);
            assign w_not_b[gi]      = (w_not[2*gi +: 2] == NY_B);
        end
    endgenerate

    always_comb begin
        w_single_data = '0;
        w_single_loop = 1'b0;
        w_single_err  = 1'b0;
        case (w_head_op)
            OP_NY_AND: begin
                w_single_data = {{WIDTH{1'b0}}, w_and};
                w_single_loop = |w_and_b;
            end
            OP_NY_OR: begin
                w_single_data = {{WIDTH{1'b0}}, w_or};
                w_single_loop = |w_or_b;
            end
            OP_NY_NOT: begin
                w_single_data = {{WIDTH{1'b0}}, w_not};
                w_single_loop = |w_not_b;
            end
            OP_ADD:  w_single_data = {{(WIDTH-1){1'b0}}, {1'b0, w_head_a} + {1'b0, w_head_b}};
            OP_MUL:  w_single_err = 1'b0;
            default: w_single_err = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the {carry, hi, lo} product right by one.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_dispatch = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_load_single = 1'b0;
        w_load_mul    = 1'b0;
        w_step        = 1'b0;
        if (r_state == S_EXEC) begin
            w_step = 1'b1;
            if (w_mul_last) w_state_next = S_RESP;
        end else if (w_dispatch) begin
            if (!w_empty) begin
                w_pop = 1'b1;
                if (w_head_op == OP_MUL) begin
                    w_load_mul   = 1'b1;
                    w_state_next = S_EXEC;
                end else begin
                    w_load_single = 1'b1;
                    w_state_next  = S_RESP;
                end
            end else begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_rsp_loop <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_load_single) begin
                r_rsp_data <= w_single_data;
                r_rsp_tag  <= w_head_tag;
                r_rsp_loop <= w_single_loop;
                r_rsp_err  <= w_single_err;
            end
            if (w_load_mul) begin
                r_mcand    <= w_head_a;
                r_hi       <= '0;
                r_lo       <= w_head_b;
                r_cnt      <= '0;
                r_rsp_tag  <= w_head_tag;
                r_rsp_loop <= 1'b0;
                r_rsp_err  <= 1'b0;
            end
            if (w_step) begin
                r_hi  <= w_mul_next[2*WIDTH-1:WIDTH];
                r_lo  <= w_mul_next[WIDTH-1:0];
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_mul_last) r_rsp_data <= w_mul_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loop_cnt <= '0;
        end else if (rsp_valid && rsp_ready && r_rsp_loop && (r_loop_cnt != 16'hFFFF)) begin
            r_loop_cnt <= r_loop_cnt + 16'd1;
        end
    end

    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_loop   = r_rsp_loop;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign loop_count = r_loop_cnt;

endmodule

// File: tb/tb_spu_exec_core.sv
// Randomised self-checking bench for spu_exec_core: a scoreboard of expected
// responses from a truth/falsity-bit model of Nyaya logic plus plain arithmetic.
module tb_spu_exec_core;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [2:0]             cmd_op = '0;
    logic [WIDTH-1:0]       cmd_a = '0;
    logic [WIDTH-1:0]       cmd_b = '0;
    logic [TAG_W-1:0]       cmd_tag = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [2*WIDTH-1:0]     rsp_data;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   rsp_loop;
    logic                   rsp_err;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   busy;
    logic [15:0]            loop_count;

    spu_exec_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_loop   (rsp_loop),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count),
        .busy       (busy),
        .loop_count (loop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2*WIDTH-1:0] data;
        logic [TAG_W-1:0]   tag;
        logic               loop;
        logic               err;
    } exp_t;

    exp_t exp_q[$];
    int   hs_q[$];
    int   model_loop = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Each Nyaya value is a pair (told-true, told-false); AND/OR act on the
    // pair componentwise and NOT swaps the two components.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [1:0] x, y, r;
        logic tx, fx, ty, fy, t, f;
        e = '0;
        e.tag = tag;
        if (op <= 3'd2) begin
            for (int i = 0; i < WIDTH / 2; i++) begin
                x  = a[2*i +: 2];
                y  = b[2*i +: 2];
                tx = (x == 2'b01) || (x == 2'b10);
                fx = (x == 2'b00) || (x == 2'b10);
                ty = (y == 2'b01) || (y == 2'b10);
                fy = (y == 2'b00) || (y == 2'b10);
                if (op == 3'd0)      begin t = tx & ty; f = fx | fy; end
                else if (op == 3'd1) begin t = tx | ty; f = fx & fy; end
                else                 begin t = fx;      f = tx;      end
                r = t ? (f ? 2'b10 : 2'b01) : (f ? 2'b00 : 2'b11);
                e.data[2*i +: 2] = r;
                if (r == 2'b10) e.loop = 1'b1;
            end
        end else if (op == 3'd3) begin
            e.data = (2*WIDTH)'(a) + (2*WIDTH)'(b);
        end else if (op == 3'd4) begin
            e.data = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Scoreboard: sampled at negedge, between the drive (posedge+1) and the
    // edge that performs the handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_tag), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    check("rsp_loop", 64'(rsp_loop), 64'(e.loop));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.loop && model_loop < 65535) model_loop++;
                    hs_q.push_back(cyc);
                end
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back(ref_model(cmd_op, cmd_a, cmd_b, cmd_tag));
        end
    end

    task automatic drive_cmd(input logic [2:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
    endtask

    // Offers a command and returns at the negedge where it is accepted,
    // leaving cmd_valid high until the caller drives the next thing.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        int n;
        @(posedge clk); #1;
        drive_cmd(op, a, b, tag);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (n >= 50) check("send_timeout", 64'(n), 64'(0));
    endtask

    task automatic do_one(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag, input int lat);
        int k, n;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drive_cmd(op, a, b, tag);
        @(negedge clk);
        check("accept_ready", 64'(cmd_ready), 64'(1));
        k = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        check("latency", 64'(cyc - k), 64'(lat));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({name, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({name, "_fifo_count"}, 64'(fifo_count), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_loop_count"}, 64'(loop_count), 64'(0));
        check({name, "_rsp_bus"}, 64'({rsp_data, rsp_tag, rsp_loop, rsp_err}), 64'(0));
    endtask

    initial begin
        int n, k5, nval, sent;
        bit acc;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        do_one(3'd0, 16'h00E4, 16'h0055, 4'd3, 2);
        repeat (2) @(negedge clk);
        check("loop_count_after_and", 64'(loop_count), 64'(model_loop));
        do_one(3'd4, 16'hFFFF, 16'hFFFF, 4'd1, 2 + WIDTH);
        do_one(3'd7, 16'h1234, 16'h5678, 4'd2, 2);
        do_one(3'd2, 16'h0009, 16'h0000, 4'd4, 2);
        do_one(3'd3, 16'hFFFF, 16'h0001, 4'd5, 2);
        do_one(3'd1, 16'h00B4, 16'h001B, 4'd6, 2);
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        // Backpressure: five fit (one in the response register, four queued).
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        hs_q.delete();
        for (int i = 0; i < 5; i++)
            send(3'd3, 16'($urandom), 16'($urandom), 4'(i));
        @(posedge clk); #1;
        drive_cmd(3'd3, 16'($urandom), 16'($urandom), 4'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_cmd_ready", 64'(cmd_ready), 64'(0));
            check("full_fifo_count", 64'(fifo_count), 64'(DEPTH));
            check("held_rsp_tag", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd0}));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 20);
        k5 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_count", 64'(hs_q.size()), 64'(6));
        if (hs_q.size() >= 6) begin
            for (int i = 0; i < 5; i++)
                check("back_to_back", 64'(hs_q[i+1] - hs_q[i]), 64'(1));
            check("tag5_accept", 64'(k5 - hs_q[0]), 64'(1));
        end

        // Reset during a multiply discards the work in flight.
        send(3'd4, 16'($urandom), 16'($urandom), 4'd9);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("exec_busy", 64'({busy, rsp_valid}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_exec_reset");
        exp_q.delete();
        model_loop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nval = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) nval++;
        end
        check("no_stale_rsp", 64'(nval), 64'(0));

        // Random traffic with random backpressure.
        sent = 0;
        acc = 1'b1;
        while (sent < 250) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (acc || !cmd_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    n = $urandom_range(0, 9);
                    drive_cmd((n > 7) ? 3'd4 : 3'(n), 16'($urandom), 16'($urandom), 4'($urandom));
                    sent++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
        end
        n = 0;
        while (cmd_valid && !acc && n < 200) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_busy", 64'(busy), 64'(0));
        check("final_fifo_count", 64'(fifo_count), 64'(0));
        check("final_loop_count", 64'(loop_count), 64'(model_loop));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
